mesh_sched_ctrl: RTL
====================

# mesh_sched_ctrl

Clocked scheduler that sequences one convolution pass through the 2x3 PE mesh. It takes raw filter and ifmap words from upstream, attaches per-PE routing headers from a route table, and injects filter packets then ifmap packets into the mesh input buffer. It then counts result packets leaving the mesh exit node until the pass completes. It sits between the host-side data streams and the mesh `Packet_in`/`Packet_out` ports.

## Interface
- FILTER_WIDTH, 8, width of one filter/ifmap element; payload carries 3 elements
- NUM_PE, 4, number of PEs addressed per pass (1..8)
- ROWS_PER_PE, 3, ifmap packets per PE per pass (1..8)
- EXPECTED_RESULTS, 4, result packets that end a pass (>=1)
- ROUTE_TABLE, 20'b01011_01111_10011_11011, NUM_PE x 5-bit routing headers {y_hop[4], x_hop[3:2], dir[1:0]}, PE0 in LSBs
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse, begins a pass; ignored while busy
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle pulse at pass end
- filt_valid / filt_ready  in / out  1 / 1  filter stream handshake
- filt_data  in  3*FILTER_WIDTH  three filter weights
- ifm_valid / ifm_ready  in / out  1 / 1  ifmap stream handshake
- ifm_data  in  3*FILTER_WIDTH  three ifmap elements
- pkt_valid / pkt_ready  out / in  1 / 1  mesh injection handshake
- pkt_data  out  9+3*FILTER_WIDTH  injected packet
- res_valid  in  1  result packet present
- res_ready  out  1  result accept; constant 1 outside reset
- res_data  in  4+3*FILTER_WIDTH  result packet (routing bits already stripped)
- result_count  out  $clog2(EXPECTED_RESULTS+1)  results received this pass
- last_result  out  4+3*FILTER_WIDTH  most recently accepted res_data
- err_stray  out  1  sticky flag: a result arrived in IDLE, or a result arrived after the count reached EXPECTED_RESULTS

## Operation
- Packet format: [4:0] = ROUTE_TABLE entry of the target PE; [7:5] = row index (ifmap) or 0 (filter); [8] = type (0 filter, 1 ifmap); [9+3*FW-1:9] = upstream data unchanged.
- FSM states: IDLE, FILTER, IFMAP, DRAIN, DONE.
- IDLE:
  - On start, go to FILTER.
  - Clear result_count and err_stray; pe_idx=0, row_idx=0.
- FILTER:
  - filt_ready = !pkt_valid || pkt_ready.
  - Each filt handshake loads one filter packet for pe_idx, then pe_idx++.
  - On the handshake with pe_idx==NUM_PE-1, go to IFMAP with pe_idx=0.
- IFMAP:
  - ifm_ready uses the same condition as filt_ready.
  - Order is row-major by row: for row_idx 0..ROWS_PER_PE-1, for pe_idx 0..NUM_PE-1.
  - On the final handshake, go to DRAIN.
- DRAIN: go to DONE when result_count==EXPECTED_RESULTS and pkt_valid==0.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- filt_ready=0 outside FILTER; ifm_ready=0 outside IFMAP.
- Results:
  - Accepted every cycle (res_ready=1).
  - While busy and count<EXPECTED_RESULTS: count++ and capture last_result.
  - Otherwise set err_stray; count saturates at EXPECTED_RESULTS.
  - Results may arrive during FILTER/IFMAP and are counted.
- A start pulse while busy is ignored, with no side effects.

## Timing
- Reset values:
  - All outputs 0, except res_ready=1 after reset deasserts.
  - res_ready=0 while reset is high.
  - State IDLE, all counters 0.
- start in cycle N: busy=1 and state=FILTER from cycle N+1; filt_ready may be high in cycle N+1.
- Injection latency: a handshake in cycle N puts the packet on pkt_data with pkt_valid=1 in cycle N+1.
- Throughput: one packet per cycle with pkt_ready held high.
- Output stall: pkt_valid/pkt_data are held stable while pkt_valid && !pkt_ready.
- Simultaneous pkt accept and upstream accept in the same cycle loads the new packet with no bubble.
- Result accepted in cycle N: result_count and last_result update in cycle N+1.
- Final result and final pkt accept in the same cycle N: DONE in N+1, done pulse in N+1, IDLE in N+2.
- Reset asserted mid-pass: immediately clears state and pkt_valid; any packet in flight is dropped; no done pulse.

## Test plan
- Single pass, defaults, all valids and pkt_ready held high:
  - 4 filter packets with headers 11011, 10011, 01111, 01011 and type 0.
  - Then 12 ifmap packets, type 1, with row 0,0,0,0,1,1,1,1,2,2,2,2.
  - 4 results -> done exactly 1 cycle; result_count=4.
- Backpressure, pkt_ready toggling 1010…: no packet lost or duplicated; pkt_data stable during stalls; filt_ready/ifm_ready low on stalled cycles.
- Early results, 2 results during FILTER: counted (result_count=2 before IFMAP); done only after the last ifmap packet drains and 4 results have arrived.
- Stray results:
  - A result in IDLE -> err_stray=1.
  - A 5th result in a pass -> err_stray=1 and result_count stays 4.
  - The next start clears err_stray.
- start asserted while busy during IFMAP -> no state change; packet order unaffected.
- Reset asserted during IFMAP after 5 ifmap packets -> all outputs return to reset values the same cycle; a new start runs a full clean pass.

Source files
------------

// File: rtl/mesh_sched_ctrl_if.sv
// Stream bundle between the pass scheduler, the host-side filter/ifmap
// sources, the mesh injection port and the mesh exit port.
interface mesh_sched_ctrl_if #(
  parameter int FILTER_WIDTH = 8
);
  localparam int DW = 3 * FILTER_WIDTH;

  logic          filt_valid;
  logic          filt_ready;
  logic [DW-1:0] filt_data;

  logic          ifm_valid;
  logic          ifm_ready;
  logic [DW-1:0] ifm_data;

  logic          pkt_valid;
  logic          pkt_ready;
  logic [DW+8:0] pkt_data;

  logic          res_valid;
  logic          res_ready;
  logic [DW+3:0] res_data;

  // Scheduler side
  modport master (
    input  filt_valid, filt_data,
    output filt_ready,
    input  ifm_valid, ifm_data,
    output ifm_ready,
    output pkt_valid, pkt_data,
    input  pkt_ready,
    input  res_valid, res_data,
    output res_ready
  );

  // Sources, mesh and result sink side
  modport slave (
    output filt_valid, filt_data,
    input  filt_ready,
    output ifm_valid, ifm_data,
    input  ifm_ready,
    input  pkt_valid, pkt_data,
    output pkt_ready,
    output res_valid, res_data,
    input  res_ready
  );
endinterface

// File: rtl/mesh_sched_ctrl.sv
// Sequences one convolution pass: routes filter then ifmap words into the
// mesh through a one-deep output register and counts returning results.
module mesh_sched_ctrl #(
  parameter int                  FILTER_WIDTH     = 8,
  parameter int                  NUM_PE           = 4,
  parameter int                  ROWS_PER_PE      = 3,
  parameter int                  EXPECTED_RESULTS = 4,
  parameter logic [5*NUM_PE-1:0] ROUTE_TABLE      = 20'b01011_01111_10011_11011
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  output logic                                     busy,
  output logic                                     done,
  output logic [$clog2(EXPECTED_RESULTS+1)-1:0]    result_count,
  output logic [4+3*FILTER_WIDTH-1:0]              last_result,
  output logic                                     err_stray,
  mesh_sched_ctrl_if.master                        bus
);

  localparam int               DW       = 3 * FILTER_WIDTH;
  localparam int               CNT_W    = $clog2(EXPECTED_RESULTS + 1);
  localparam logic [2:0]       LAST_PE  = 3'(NUM_PE - 1);
  localparam logic [2:0]       LAST_ROW = 3'(ROWS_PER_PE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(EXPECTED_RESULTS);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(EXPECTED_RESULTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILTER,
    S_IFMAP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [2:0]    pe_idx;
  logic [2:0]    pe_nxt;
  logic [2:0]    row_idx;
  logic [2:0]    row_nxt;
  logic          can_load;
  logic          filt_hs;
  logic          ifm_hs;
  logic          res_count_en;
  logic          results_full_nxt;
  logic [4:0]    route_hdr;

  // The output register may take a new packet when empty or emptying now.
  assign can_load      = !bus.pkt_valid || bus.pkt_ready;
  assign bus.filt_ready = (state == S_FILTER) && can_load;
  assign bus.ifm_ready  = (state == S_IFMAP) && can_load;
  assign filt_hs       = bus.filt_valid && bus.filt_ready;
  assign ifm_hs        = bus.ifm_valid && bus.ifm_ready;
  assign bus.res_ready  = !reset;

  assign busy = (state == S_FILTER) || (state == S_IFMAP) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  assign res_count_en     = bus.res_valid && busy && (result_count != CNT_MAX);
  assign results_full_nxt = (result_count == CNT_MAX) ||
                            (res_count_en && (result_count == CNT_PEN));

  always_comb begin
    route_hdr = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (pe_idx == 3'(i)) begin
        route_hdr = ROUTE_TABLE[5*i +: 5];
      end
    end
  end

  // Drain looks at next-cycle count and occupancy so a final result and a
  // final packet accept in the same cycle reach DONE on the very next edge.
  always_comb begin
    state_nxt = state;
    pe_nxt    = pe_idx;
    row_nxt   = row_idx;
    case (state)
      S_IDLE: begin
        pe_nxt  = '0;
        row_nxt = '0;
        if (start) begin
          state_nxt = S_FILTER;
        end
      end
      S_FILTER: begin
        if (filt_hs) begin
          if (pe_idx == LAST_PE) begin
            pe_nxt    = '0;
            state_nxt = S_IFMAP;
          end else begin
            pe_nxt = pe_idx + 3'd1;
          end
        end
      end
      S_IFMAP: begin
        if (ifm_hs) begin
          if (pe_idx == LAST_PE) begin
            pe_nxt = '0;
            if (row_idx == LAST_ROW) begin
              state_nxt = S_DRAIN;
            end else begin
              row_nxt = row_idx + 3'd1;
            end
          end else begin
            pe_nxt = pe_idx + 3'd1;
          end
        end
      end
      S_DRAIN: begin
        if (results_full_nxt && can_load) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pe_idx  <= '0;
      row_idx <= '0;
    end else begin
      state   <= state_nxt;
      pe_idx  <= pe_nxt;
      row_idx <= row_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.pkt_valid <= 1'b0;
      bus.pkt_data  <= '0;
    end else if (filt_hs) begin
      bus.pkt_valid <= 1'b1;
      bus.pkt_data  <= {bus.filt_data, 1'b0, 3'b000, route_hdr};
    end else if (ifm_hs) begin
      bus.pkt_valid <= 1'b1;
      bus.pkt_data  <= {bus.ifm_data, 1'b1, row_idx, route_hdr};
    end else if (bus.pkt_ready) begin
      bus.pkt_valid <= 1'b0;
    end
  end

  // A result seen in IDLE is stray even on the cycle a new pass starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_count <= '0;
      last_result  <= '0;
      err_stray    <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      result_count <= '0;
      err_stray    <= bus.res_valid;
    end else if (res_count_en) begin
      result_count <= result_count + CNT_W'(1);
      last_result  <= bus.res_data;
    end else if (bus.res_valid) begin
      err_stray    <= 1'b1;
    end
  end

endmodule
